// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder time-sharing controller.
//   ctrl_state_t : controller FSM states
//   LAT_CNT_W    : width of the adder latency down-counter (ADD_LATENCY <= 7)
package adder_share_pkg;

  localparam int unsigned LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } ctrl_state_t;

endpackage

// File: rtl/adder_rr_picker.sv
// Round-robin picker, purely combinational.
// Rotates the valid vector so that index ptr lands at bit 0, priority-encodes
// the lowest set bit, then rotates the result back to an absolute index.
// Ports:
//   valid     : per-requester valid vector
//   ptr       : highest-priority index for this pick
//   any_valid : at least one requester is valid
//   grant     : index of the first valid requester at or after ptr (mod NUM_REQ)
module adder_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_valid,
  output logic [IDX_W-1:0]   grant
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic               found;

  // rot[i] is the requester i positions after ptr
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rot[i] = valid[IDX_W'((i + 32'(ptr)) % NUM_REQ)];
    end
  end

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  assign any_valid = found;
  assign grant     = IDX_W'((32'(off) + 32'(ptr)) % NUM_REQ);

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller time-sharing one fixed-latency adder among NUM_REQ
// requesters. A grant latches one requester's operands, pulses add_start,
// captures sum/carry ADD_LATENCY cycles later and returns them tagged with
// the requester index.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b, req_cin: per-requester operands, element i = requester i
//   add_start            : one-cycle start pulse to the shared adder
//   add_a, add_b, add_cin: latched operands held for the whole operation
//   add_sum, add_cout    : adder result, valid ADD_LATENCY cycles after start
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id, rsp_sum, rsp_cout : served requester index and captured result
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int unsigned  NUM_REQ     = 4,
  parameter int unsigned  WIDTH       = 8,
  parameter int unsigned  ADD_LATENCY = 2,
  localparam int unsigned IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic                          add_start,
  output logic [WIDTH-1:0]              add_a,
  output logic [WIDTH-1:0]              add_b,
  output logic                          add_cin,
  input  logic [WIDTH-1:0]              add_sum,
  input  logic                          add_cout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDX_W-1:0]              rsp_id,
  output logic [WIDTH-1:0]              rsp_sum,
  output logic                          rsp_cout
);

  ctrl_state_t          state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     id_q, id_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 cin_q, cin_d;
  logic                 start_q, start_d;
  logic [IDX_W-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_sum_q, rsp_sum_d;
  logic                 rsp_cout_q, rsp_cout_d;

  logic             any_valid;
  logic [IDX_W-1:0] grant;

  adder_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .any_valid (any_valid),
    .grant     (grant)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    start_d    = 1'b0;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    req_ready  = '0;

    unique case (state_q)
      IDLE: begin
        // Handshake completes combinationally; rst masks the grant.
        if (any_valid && !rst) begin
          req_ready[grant] = 1'b1;
          id_d    = grant;
          a_d     = req_a[grant];
          b_d     = req_b[grant];
          cin_d   = req_cin[grant];
          cnt_d   = LAT_CNT_W'(ADD_LATENCY);
          start_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          rsp_id_d   = id_q;
          rsp_sum_d  = add_sum;
          rsp_cout_d = add_cout;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = IDX_W'((32'(id_q) + 32'd1) % NUM_REQ);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      start_q    <= 1'b0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      start_q    <= start_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  assign add_start = start_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl (NUM_REQ=4, WIDTH=8, ADD_LATENCY=2).
// A transaction-level model predicts every output each cycle; directed tests
// add literal expectations.
module tb_adder_share_ctrl;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_cin;
  logic [N-1:0][W-1:0] req_a, req_b;
  logic              add_start, add_cin, add_cout;
  logic [W-1:0]      add_a, add_b, add_sum;
  logic              rsp_valid, rsp_ready, rsp_cout;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;

  always #5 clk = ~clk;

  adder_share_ctrl #(
    .NUM_REQ     (N),
    .WIDTH       (W),
    .ADD_LATENCY (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  // Shared adder: result only valid exactly L cycles after a start, garbage otherwise.
  logic [W:0] st0, st1;
  always @(posedge clk) begin
    st0 <= add_start ? ({1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin}) : {1'b1, 8'h5A};
    st1 <= st0;
  end
  assign add_sum  = st1[W-1:0];
  assign add_cout = st1[W];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model state: one operation in flight, identified by its handshake cycle.
  bit           m_have;
  int           m_t, m_id, m_ptr;
  logic [W-1:0] m_a, m_b;
  logic         m_cin;
  typedef struct {int idx; int cyc;} gl_t;
  gl_t glog[$];

  int           g, idx;
  logic [N-1:0] exp_rdy;
  logic         exp_rv;
  logic [W:0]   s;

  initial begin
    m_have = 0;
    m_ptr  = 0;
    forever begin
      @(negedge clk);
      g = -1;
      if (!rst && !m_have) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx[1:0]]) g = idx;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g[1:0]] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("add_start", 32'(add_start), 32'(m_have && cyc == m_t + 1));
      if (m_have && cyc >= m_t + 1 && cyc <= m_t + 1 + L) begin
        chk("add_a", 32'(add_a), 32'(m_a));
        chk("add_b", 32'(add_b), 32'(m_b));
        chk("add_cin", 32'(add_cin), 32'(m_cin));
      end
      exp_rv = m_have && cyc >= m_t + 2 + L;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        s = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_sum", 32'(rsp_sum), 32'(s[W-1:0]));
        chk("rsp_cout", 32'(rsp_cout), 32'(s[W]));
      end
      for (int k = 0; k < N; k++) if (req_ready[k]) glog.push_back('{k, cyc});
      if (rst) begin
        m_have = 0;
        m_ptr  = 0;
      end else if (g >= 0) begin
        m_have = 1;
        m_t    = cyc;
        m_id   = g;
        m_a    = req_a[g[1:0]];
        m_b    = req_b[g[1:0]];
        m_cin  = req_cin[g[1:0]];
      end else if (exp_rv && rsp_ready) begin
        m_have = 0;
        m_ptr  = (m_id + 1) % N;
      end
      cyc++;
    end
  end

  // Requesters drop valid after their handshake unless marked persistent.
  logic [N-1:0] keep = '0;
  logic [N-1:0] hs;
  initial forever begin
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #2;
    req_valid = req_valid & ~(hs & ~keep);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    req_a[i]     = a;
    req_b[i]     = b;
    req_cin[i]   = c;
    req_valid[i] = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_add_start"}, 32'(add_start), 0);
    chk({tag, "_add_a"}, 32'(add_a), 0);
    chk({tag, "_add_b"}, 32'(add_b), 0);
    chk({tag, "_add_cin"}, 32'(add_cin), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_sum"}, 32'(rsp_sum), 0);
    chk({tag, "_rsp_cout"}, 32'(rsp_cout), 0);
  endtask

  task automatic settle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!m_have && req_valid == '0) done = 1;
    end
    chk("settle_timeout", 32'(done), 1);
    next_cyc();
  endtask

  task automatic wait_glog(input int n);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (glog.size() >= n) ok = 1;
    end
    chk("grant_timeout", 32'(ok), 1);
  endtask

  logic [W-1:0] h_sum;
  logic [1:0]   h_id;
  logic         h_cout;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    rsp_ready = 1'b1;

    // Reset values, during and right after reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("in_reset");
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");
    next_cyc();

    // 1: single request from requester 2
    set_req(2, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    chk("t1_start", 32'(add_start), 1);
    chk("t1_add_a", 32'(add_a), 32'h7F);
    @(negedge clk);
    chk("t1_no_rsp_c2", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_no_rsp_c3", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 2);
    chk("t1_rsp_sum", 32'(rsp_sum), 32'h80);
    chk("t1_rsp_cout", 32'(rsp_cout), 0);
    settle();

    // 2: overflow with carry-in
    set_req(1, 8'hFF, 8'h01, 1'b1);
    repeat (5) @(negedge clk);
    chk("t2_rsp_valid", 32'(rsp_valid), 1);
    chk("t2_rsp_id", 32'(rsp_id), 1);
    chk("t2_rsp_sum", 32'(rsp_sum), 32'h01);
    chk("t2_rsp_cout", 32'(rsp_cout), 1);
    settle();

    // 3: all four valid from reset
    glog.delete();
    rst  = 1'b1;
    keep = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 16 + 3), 8'(i * 8 + 8'hF0), i[0]);
    next_cyc();
    next_cyc();
    rst = 1'b0;
    wait_glog(4);
    keep = '0;
    for (int k = 0; k < 4; k++) chk("t3_order", 32'(glog[k].idx), 32'(k));
    for (int k = 0; k < 3; k++) chk("t3_spacing", 32'(glog[k + 1].cyc - glog[k].cyc), 5);
    settle();

    // 4: backpressure for 10 RESP cycles, second requester waits
    rsp_ready = 1'b0;
    set_req(1, 8'h12, 8'h34, 1'b1);
    set_req(2, 8'h80, 8'h80, 1'b0);
    @(negedge clk);
    chk("t4_grant", 32'(req_ready), 32'h2);
    repeat (4) @(negedge clk);
    chk("t4_rsp_valid", 32'(rsp_valid), 1);
    chk("t4_rsp_id", 32'(rsp_id), 1);
    chk("t4_rsp_sum", 32'(rsp_sum), 32'h47);
    chk("t4_rsp_cout", 32'(rsp_cout), 0);
    h_id = rsp_id;
    h_sum = rsp_sum;
    h_cout = rsp_cout;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid), 1);
      chk("t4_hold_id", 32'(rsp_id), 32'(h_id));
      chk("t4_hold_sum", 32'(rsp_sum), 32'(h_sum));
      chk("t4_hold_cout", 32'(rsp_cout), 32'(h_cout));
      chk("t4_no_ready", 32'(req_ready), 0);
      chk("t4_no_start", 32'(add_start), 0);
    end
    next_cyc();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    chk("t4_done", 32'(rsp_valid), 0);
    chk("t4_next_grant", 32'(req_ready), 32'h4);
    settle();

    // 5: reset during BUSY, then requesters 3 and 0
    set_req(1, 8'h10, 8'h20, 1'b0);
    @(negedge clk);
    chk("t5_grant", 32'(req_ready), 32'h2);
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("t5_after_rst");
    next_cyc();
    set_req(3, 8'hF0, 8'h0F, 1'b1);
    set_req(0, 8'h01, 8'h02, 1'b0);
    @(negedge clk);
    chk("t5_first_grant", 32'(req_ready), 32'h1);
    repeat (4) @(negedge clk);
    chk("t5_rsp_valid", 32'(rsp_valid), 1);
    chk("t5_rsp_id", 32'(rsp_id), 0);
    chk("t5_rsp_sum", 32'(rsp_sum), 32'h03);
    settle();

    // 6: requesters 1 and 3 continuously valid
    glog.delete();
    keep = 4'b1010;
    set_req(1, 8'h55, 8'hAA, 1'b1);
    set_req(3, 8'hC3, 8'h3C, 1'b0);
    wait_glog(4);
    keep = '0;
    chk("t6_g0", 32'(glog[0].idx), 1);
    chk("t6_g1", 32'(glog[1].idx), 3);
    chk("t6_g2", 32'(glog[2].idx), 1);
    chk("t6_g3", 32'(glog[3].idx), 3);
    settle();

    repeat (5) next_cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Round-robin controller that time-shares one fixed-latency adder datapath among NUM_REQ requesters. Each requester presents operands with a valid/ready handshake. The controller grants one requester, drives the adder with a start pulse, captures the sum and carry after ADD_LATENCY cycles, and returns them on a single response channel tagged with the requester index. It sits between requester blocks and the single shared adder instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- WIDTH, 8: operand/sum width in bits
- ADD_LATENCY, 2: cycles from add_start to valid add_sum/add_cout, 0..7 (0 = combinational adder)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_a, req_b  in  NUM_REQ×WIDTH  packed arrays, element i belongs to requester i
- req_cin  in  NUM_REQ  carry-in per requester
- add_start  out  1  one-cycle start pulse to the shared adder
- add_a, add_b  out  WIDTH  latched operands to the adder
- add_cin  out  1  latched carry-in to the adder
- add_sum  in  WIDTH  adder sum
- add_cout  in  1  adder carry-out
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NUM_REQ)  index of the served requester
- rsp_sum  out  WIDTH  captured sum
- rsp_cout  out  1  captured carry-out

## Operation
- Uses a 3-state FSM: IDLE, BUSY and RESP.
- **IDLE**
  - If any req_valid is high, pick the first valid index at or after ptr, wrapping modulo NUM_REQ.
  - Drive req_ready[g] high combinationally in the same cycle. The handshake completes in that cycle.
  - Latch req_a[g], req_b[g], req_cin[g] and g. Go to BUSY.
  - If no request is valid, stay in IDLE with all req_ready low.
- **BUSY**
  - add_start is high only in the first BUSY cycle. add_a/add_b/add_cin hold the latched values for all of BUSY.
  - A 3-bit counter loads ADD_LATENCY on entry and decrements each cycle.
  - In the cycle the counter is 0, capture add_sum/add_cout into the rsp registers and go to RESP.
- **RESP**
  - rsp_valid is high. On rsp_valid && rsp_ready, set ptr to (g+1) mod NUM_REQ and go to IDLE.
- req_ready is low in BUSY and RESP. Requesters that assert valid meanwhile wait.
- Requesters must hold valid and operands stable until ready. Dropping valid early is a protocol violation. The controller samples operands only in the handshake cycle.
- The controller does no arithmetic. rsp_sum and rsp_cout are exactly what the adder produced.

## Timing
- Reset values: state IDLE, ptr 0, counter 0, req_ready 0, add_start 0, add_a/add_b/add_cin 0, rsp_valid 0, rsp_id/rsp_sum/rsp_cout 0.
- While rst is high, req_ready is forced to 0.
- Latency, with the handshake in cycle T:
  - add_start is high in cycle T+1.
  - The adder output is sampled at the end of cycle T+1+ADD_LATENCY.
  - rsp_valid first goes high in cycle T+2+ADD_LATENCY.
- Throughput with rsp_ready tied high: one operation per ADD_LATENCY+3 cycles.
- Backpressure: while rsp_ready is low, hold rsp_valid, rsp_id, rsp_sum and rsp_cout stable. No new grant and no add_start. rsp_ready high without rsp_valid has no effect.
- Simultaneous requests are resolved by the round-robin order from ptr. A continuously valid requester is served again only after every other valid requester.
- Reset mid-operation, in BUSY or RESP:
  - The in-flight operation is dropped, with no response.
  - Any late adder output is ignored.
  - ptr returns to 0.

## Structure
- Package adder_share_pkg:
  - ctrl_state_t enum {IDLE, BUSY, RESP}.
  - Constant LAT_CNT_W = 3.
- Sub-module adder_rr_picker, purely combinational:
  - Inputs: valid vector and ptr.
  - Outputs: any_valid and grant index.
  - Implemented as a rotate, priority-encode, rotate-back scheme.
- The controller top holds the FSM, latency counter, operand/ID latches and response registers.

## Test plan
Configuration: NUM_REQ=4, WIDTH=8, ADD_LATENCY=2, with a bench adder model returning a+b+cin after the latency. Handshake is at cycle 0.

1. Single request: requester 2 valid with a=0x7F, b=0x01, cin=0 in cycle 0 after reset.
   - Required: req_ready=0b0100 in cycle 0, add_start in cycle 1 with add_a=0x7F, rsp_valid in cycle 4 with rsp_id=2, rsp_sum=0x80, rsp_cout=0.
2. Overflow: a=0xFF, b=0x01, cin=1.
   - Required: rsp_sum=0x01, rsp_cout=1.
3. All four requesters valid from reset with rsp_ready=1.
   - Required: grants in order 0,1,2,3, five cycles apart, and each rsp_id matches its operands.
4. rsp_ready held low for 10 cycles during RESP.
   - Required: rsp fields stable, rsp_valid high throughout, no req_ready, no add_start. The response completes on the first cycle rsp_ready is high.
5. rst asserted for 1 cycle during BUSY, then requesters 3 and 0 valid.
   - Required: all outputs 0 the cycle after reset, no response for the aborted operation, requester 0 granted first.
6. Requesters 1 and 3 continuously valid.
   - Required: grants alternate 1,3,1,3 and neither requester is starved.
